// File: rtl/stparam_pkg.sv
// Shared types and sizes for the command/parameter fetch engine.
package stparam_pkg;

   localparam int unsigned PcWidth  = 20;
   localparam int unsigned CmdBytes = 1;
   localparam int unsigned ParBytes = 12;
   localparam int unsigned SelWidth = 4;

   typedef enum logic [2:0] {
      StIdle,
      StBusrq,
      StRdmem,
      StLoad,
      StNext,
      StDone
   } state_e;

   // Command bytes use REGSEL 0..CmdBytes-1, parameter bytes use 1..ParBytes.
   function automatic logic last_byte(input logic is_par, input logic [SelWidth-1:0] sel);
      return sel == (is_par ? SelWidth'(ParBytes) : SelWidth'(CmdBytes - 1));
   endfunction

endpackage

// File: rtl/stparam_pc.sv
// Program counter: loadable, increments modulo 2^PcWidth on request.
module stparam_pc
   import stparam_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               en_i,
   input  logic               ld_i,
   input  logic [PcWidth-1:0] ld_val_i,
   input  logic               inc_i,
   output logic [PcWidth-1:0] pc_o
);

   logic [PcWidth-1:0] pc_q;
   logic [PcWidth-1:0] pc_d;

   always_comb begin
      pc_d = pc_q;
      if (en_i) begin
         if (ld_i) begin
            pc_d = ld_val_i;
         end else if (inc_i) begin
            pc_d = pc_q + PcWidth'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_q <= '0;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/stparam.sv
// Fetches a command byte or a 12-byte parameter block over a request/grant bus.
// Define STPARAM_HOLDBUS_EN to keep BREQ asserted across all bytes of a block.
module stparam
   import stparam_pkg::*;
(
   input  logic                MasterClock,
   input  logic                SRESET,
   input  logic                CCLK,
   input  logic                RDCMD,
   input  logic                RDPAR,
   output logic                COMDN,
   output logic                PARDN,
   input  logic                PCLD,
   input  logic [PcWidth-1:0]  PCIN,
   output logic                BREQ,
   input  logic                BGACK,
   output logic                MREQ,
   input  logic                MACK,
   output logic [PcWidth-1:0]  ADDR,
   input  logic [7:0]          DIN,
   output logic                LDREG,
   output logic [SelWidth-1:0] REGSEL,
   output logic [7:0]          DOUT
);

`ifdef STPARAM_HOLDBUS_EN
   localparam logic HoldBus = 1'b1;
`else
   localparam logic HoldBus = 1'b0;
`endif

   state_e              state_q, state_d;
   logic                is_par_q, is_par_d;
   logic                pend_q, pend_d;
   logic [SelWidth-1:0] sel_q, sel_d;
   logic [7:0]          dout_q, dout_d;
   logic                pc_ld;
   logic                pc_inc;
   logic [PcWidth-1:0]  pc;

   always_comb begin
      state_d  = state_q;
      is_par_d = is_par_q;
      pend_d   = pend_q;
      sel_d    = sel_q;
      dout_d   = dout_q;
      pc_ld    = 1'b0;
      pc_inc   = 1'b0;
      if (CCLK) begin
         unique case (state_q)
            StIdle: begin
               pc_ld = PCLD;
               if (RDCMD) begin
                  state_d  = StBusrq;
                  is_par_d = 1'b0;
                  sel_d    = '0;
                  // A simultaneous parameter request is served right after the command.
                  pend_d   = pend_q | RDPAR;
               end else if (RDPAR || pend_q) begin
                  state_d  = StBusrq;
                  is_par_d = 1'b1;
                  sel_d    = SelWidth'(1);
                  pend_d   = 1'b0;
               end
            end
            StBusrq: begin
               if (BGACK) begin
                  state_d = StRdmem;
               end
            end
            StRdmem: begin
               if (!BGACK) begin
                  state_d = StBusrq;
               end else if (MACK) begin
                  dout_d  = DIN;
                  state_d = StLoad;
               end
            end
            StLoad: begin
               state_d = StNext;
            end
            StNext: begin
               pc_inc = 1'b1;
               if (last_byte(is_par_q, sel_q)) begin
                  state_d = StDone;
               end else begin
                  sel_d   = sel_q + SelWidth'(1);
                  state_d = HoldBus ? StRdmem : StBusrq;
               end
            end
            StDone: begin
               state_d = StIdle;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge MasterClock) begin
      if (SRESET) begin
         state_q  <= StIdle;
         is_par_q <= 1'b0;
         pend_q   <= 1'b0;
         sel_q    <= '0;
         dout_q   <= '0;
      end else begin
         state_q  <= state_d;
         is_par_q <= is_par_d;
         pend_q   <= pend_d;
         sel_q    <= sel_d;
         dout_q   <= dout_d;
      end
   end

   stparam_pc u_pc (
      .clk_i    (MasterClock),
      .rst_i    (SRESET),
      .en_i     (CCLK),
      .ld_i     (pc_ld),
      .ld_val_i (PCIN),
      .inc_i    (pc_inc),
      .pc_o     (pc)
   );

   always_comb begin
      BREQ = 1'b0;
      unique case (state_q)
         StBusrq, StRdmem, StLoad: BREQ = 1'b1;
         StNext:                   BREQ = HoldBus;
         default:                  BREQ = 1'b0;
      endcase
   end

   assign MREQ   = (state_q == StRdmem);
   assign LDREG  = (state_q == StLoad);
   assign COMDN  = (state_q == StDone) && !is_par_q;
   assign PARDN  = (state_q == StDone) && is_par_q;
   assign REGSEL = sel_q;
   assign DOUT   = dout_q;
   assign ADDR   = pc;

endmodule

// File: doc/stparam.md
STPARAM -- requirements
Module: stparam

Interface
REQ-001 SHALL have port MasterClock  in  1  sole clock; all state changes on its rising edge.
REQ-002 SHALL have port SRESET  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port CCLK  in  1  clock enable; state advances only on edges where CCLK=1.
REQ-004 SHALL have port RDCMD  in  1  outer-loop request to fetch the command byte.
REQ-005 SHALL have port RDPAR  in  1  outer-loop request to fetch the parameter block.
REQ-006 SHALL have port COMDN  out  1  command fetch complete, one enabled cycle.
REQ-007 SHALL have port PARDN  out  1  parameter fetch complete, one enabled cycle.
REQ-008 SHALL have port PCLD / PCIN  in  1 / 20  load program counter with PCIN.
REQ-009 SHALL have port BREQ / BGACK  out / in  1 / 1  bus request / grant.
REQ-010 SHALL have port MREQ / MACK  out / in  1 / 1  memory read strobe / acknowledge.
REQ-011 SHALL have port ADDR  out  20  read address, equal to PC.
REQ-012 SHALL have port DIN  in  8  read data, valid with MACK.
REQ-013 SHALL have port LDREG / REGSEL / DOUT  out  1 / 4 / 8  one-cycle register-load strobe, register index, byte.

Function
REQ-014 SHALL implement the states IDLE, BUSRQ, RDMEM, LOAD, NEXT and DONE.
REQ-015 IDLE SHALL start a command fetch on RDCMD=1, or a parameter fetch on RDPAR=1; RDCMD wins when both are high, and RDPAR stays pending until sampled again.
REQ-016 A command fetch SHALL read 1 byte (REGSEL 0); a parameter fetch SHALL read 12 bytes (REGSEL 1..12, ascending).
REQ-017 BUSRQ SHALL hold BREQ=1 until BGACK=1, then go to RDMEM.
REQ-018 RDMEM SHALL hold MREQ=1 with ADDR=PC until MACK=1, capture DIN into DOUT, then go to LOAD.
REQ-019 LOAD SHALL assert LDREG for exactly one enabled cycle with stable REGSEL and DOUT.
REQ-020 NEXT SHALL increment PC modulo 2^20 (0xFFFFF wraps to 0x00000), then go to DONE after the last byte, or otherwise back to RDMEM/BUSRQ per REQ-027.
REQ-021 DONE SHALL pulse COMDN or PARDN (matching the fetch type) for one enabled cycle, drop BREQ, and return to IDLE.
REQ-022 PCLD SHALL load PC only in IDLE; PCLD during a fetch SHALL be ignored.
REQ-023 BGACK deasserting mid-fetch SHALL stall the FSM in BUSRQ with BREQ=1; no byte is lost or duplicated.
REQ-024 Minimum latency for a command fetch with BGACK and MACK already high SHALL be 5 enabled cycles from RDCMD to COMDN.

Reset
REQ-025 SRESET=1 SHALL force IDLE, PC=0, pending RDPAR cleared, and BREQ, MREQ, LDREG, COMDN, PARDN, DOUT and REGSEL all 0 on the same edge, regardless of CCLK.
REQ-026 Reset mid-fetch SHALL release the bus immediately and produce no done pulse.

Configuration
REQ-027 Macro STPARAM_HOLDBUS_EN: when defined, BREQ SHALL remain high across all bytes of a block (NEXT returns to RDMEM); when undefined, BREQ SHALL drop in NEXT and be re-requested per byte (NEXT returns to BUSRQ).

Structure
REQ-028 The state enum, byte counts (1 and 12) and the PC width (20) SHALL live in shared package stparam_pkg.
REQ-029 The PC register, incrementer and load SHALL form one sub-module, stparam_pc.

Verification
REQ-030 Load PC=0x01000 in IDLE, RDCMD with BGACK=MACK=1, DIN=0x5A -> LDREG with REGSEL=0 and DOUT=0x5A, COMDN after 5 enabled cycles, PC=0x01001.
REQ-031 RDPAR with PC=0xFFFFA -> 12 LDREGs, REGSEL 1..12, ADDR 0xFFFFA..0xFFFFF then 0x00000..0x00005, one PARDN.
REQ-032 RDCMD and RDPAR asserted together -> command completes (COMDN) first, then the parameter fetch runs and ends with PARDN.
REQ-033 BGACK dropped after byte 4 of a parameter fetch for 10 cycles -> FSM stalls, resumes at byte 5, exactly 12 LDREGs total.
REQ-034 SRESET during byte 7 -> all outputs 0 on the next edge, no PARDN, PC=0.
REQ-035 MACK delayed 3 cycles and CCLK toggling every other cycle -> MREQ held throughout, correct DOUT captured, each strobe lasts exactly one enabled cycle.
